// File: rtl/bias2_delta_gen.sv
// bias2_delta_gen: computes the five layer-2 bias deltas -(lr * err_k) in Q8.8
// through one shared multiplier, one slot per cycle. Once all five are in
// place it issues a single-cycle accumulate command to the bias2 bank.
module bias2_delta_gen #(
  parameter int         WIDTH    = 16,
  parameter int         FRAC     = 8,
  parameter logic [3:0] CTRL_UPD = 4'b0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       step_in,
  input  logic [WIDTH-1:0] lr,
  input  logic [WIDTH-1:0] err_1,
  input  logic [WIDTH-1:0] err_2,
  input  logic [WIDTH-1:0] err_3,
  input  logic [WIDTH-1:0] err_4,
  input  logic [WIDTH-1:0] err_5,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ctrl,
  output logic [3:0]       step,
  output logic [WIDTH-1:0] deltab2_1,
  output logic [WIDTH-1:0] deltab2_2,
  output logic [WIDTH-1:0] deltab2_3,
  output logic [WIDTH-1:0] deltab2_4,
  output logic [WIDTH-1:0] deltab2_5
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q;
  logic signed [WIDTH-1:0] err_q   [5];
  logic signed [WIDTH-1:0] lr_q;
  logic [3:0]              step_q;
  logic [WIDTH-1:0]        delta_q [5];

  logic signed [PW-1:0]    prod;
  logic signed [PW:0]      neg;
  logic signed [PW:0]      shr;
  logic [WIDTH-1:0]        sat;

  // Shared multiplier: negate in one extra bit so -(-32768 * -32768) fits,
  // floor-shift back to Q8.8, then clamp to the 16-bit signed range.
  always_comb begin
    prod = err_q[idx_q] * lr_q;
    neg  = -($signed({prod[PW-1], prod}));
    shr  = neg >>> FRAC;
    if (shr > SAT_MAX) begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shr < SAT_MIN) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = shr[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and command decode; every output is a decode of state_q, so
  // nothing on the inputs reaches the outputs within a cycle.
  // NOTE: every signal gets a default first so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    ctrl    = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (idx_q == 3'd4) state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        done    = 1'b1;
        ctrl    = CTRL_UPD;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on acceptance, then one delta slot written per CALC cycle.
  // NOTE: the small operand/delta arrays are reset too, because a reset must visibly zero the deltas.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 3'd0;
      lr_q   <= '0;
      step_q <= 4'd0;
      for (int i = 0; i < 5; i++) begin
        err_q[i]   <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && start) begin
        idx_q    <= 3'd0;
        lr_q     <= lr;
        step_q   <= step_in;
        err_q[0] <= err_1;
        err_q[1] <= err_2;
        err_q[2] <= err_3;
        err_q[3] <= err_4;
        err_q[4] <= err_5;
      end else if (state_q == CALC) begin
        delta_q[idx_q] <= sat;
        idx_q          <= idx_q + 3'd1;
      end
    end
  end

  assign step      = step_q;
  assign deltab2_1 = delta_q[0];
  assign deltab2_2 = delta_q[1];
  assign deltab2_3 = delta_q[2];
  assign deltab2_4 = delta_q[3];
  assign deltab2_5 = delta_q[4];

endmodule

// File: tb/tb_bias2_delta_gen.sv
// tb_bias2_delta_gen: scoreboard bench. Expected deltas are computed from the
// operands when an update is launched; the monitor compares them on done.
module tb_bias2_delta_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  step_in = 4'd0;
  logic [15:0] lr = 16'd0;
  logic [15:0] err_v [5];
  logic        busy, done;
  logic [3:0]  ctrl, step;
  logic [15:0] d1, d2, d3, d4, d5;

  typedef struct packed {
    logic [4:0][15:0] d;
    logic [3:0]       step;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   commits = 0;
  time  done_t [$];

  bias2_delta_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_in(step_in), .lr(lr),
    .err_1(err_v[0]), .err_2(err_v[1]), .err_3(err_v[2]), .err_4(err_v[3]), .err_5(err_v[4]),
    .busy(busy), .done(done), .ctrl(ctrl), .step(step),
    .deltab2_1(d1), .deltab2_2(d2), .deltab2_3(d3), .deltab2_4(d4), .deltab2_5(d5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, negate, floor-divide by 256, clamp.
  function automatic logic [15:0] model(input logic [15:0] e, input logic [15:0] l);
    longint a, b, n, s;
    a = longint'($signed(e));
    b = longint'($signed(l));
    n = -(a * b);
    if (n >= 0) s = n / 256;
    else        s = -((-n + 255) / 256);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic exp_t predict();
    exp_t x;
    for (int i = 0; i < 5; i++) x.d[i] = model(err_v[i], lr);
    x.step = step_in;
    return x;
  endfunction

  // Monitor: on done, pop the oldest expectation and compare the bank view.
  always @(negedge clk) begin
    if (done) begin
      exp_t x;
      commits++;
      done_t.push_back($time);
      check("ctrl_on_done", {28'd0, ctrl}, 32'h1);
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        x = q.pop_front();
        check("delta1", {16'd0, d1}, {16'd0, x.d[0]});
        check("delta2", {16'd0, d2}, {16'd0, x.d[1]});
        check("delta3", {16'd0, d3}, {16'd0, x.d[2]});
        check("delta4", {16'd0, d4}, {16'd0, x.d[3]});
        check("delta5", {16'd0, d5}, {16'd0, x.d[4]});
        check("step", {28'd0, step}, {28'd0, x.step});
      end
    end else if (ctrl !== 4'd0) begin
      check("ctrl_idle", {28'd0, ctrl}, 32'd0);
    end
  end

  task automatic set_ops(input logic [15:0] l, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                         input logic [3:0] s);
    lr = l; err_v[0] = e0; err_v[1] = e1; err_v[2] = e2; err_v[3] = e3; err_v[4] = e4;
    step_in = s;
  endtask

  // Launch one update from IDLE, scramble inputs and poke start while busy,
  // then wait (bounded) for done and check its latency.
  task automatic run_update(input logic [15:0] l, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                            input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    set_ops(l, e0, e1, e2, e3, e4, s);
    start = 1'b1;
    @(posedge clk); #1;
    q.push_back(predict());
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 4'($urandom));
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (done) break;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
    else       check("latency", n, 32'd6);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 5; i++) err_v[i] = 16'd0;

    // 1: reset, then idle with no start.
    #23 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step", {28'd0, step}, 32'd0);
    check("rst_deltas", {d1 | d2 | d3 | d4 | d5}, 32'd0);

    // 2: basic update.
    run_update(16'h0080, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd3);
    check("t2_d1_const", {16'd0, d1}, 32'h0000FF00);
    // 3: saturation both ways; 4: floor rounding; plus mixed values and step=0.
    run_update(16'h7FFF, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0100, 4'd5);
    run_update(16'h0001, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 4'd9);
    run_update(16'h8000, 16'h8000, 16'h7FFF, 16'h1234, 16'hF00D, 16'h0001, 4'd0);
    run_update(16'h0019, 16'h0300, 16'hFD00, 16'h1000, 16'hE000, 16'h00FF, 4'd15);

    // 5: start held for 20 cycles with changing inputs -> accepts at 0, 7, 14.
    @(posedge clk); #1;
    c0 = commits;
    done_t.delete();
    for (int c = 0; c < 20; c++) begin
      set_ops(16'(c * 37 + 5), 16'(c * 1000), 16'(-c * 300), 16'(c << 9), 16'h7FFF, 16'(c),
              4'(c));
      start = 1'b1;
      if (c % 7 == 0) q.push_back(predict());
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_commits", commits - c0, 32'd3);
    if (done_t.size() >= 3) begin
      check("period_a", 32'(done_t[1] - done_t[0]), 32'd70);
      check("period_b", 32'(done_t[2] - done_t[1]), 32'd70);
    end
    check("queue_drained", q.size(), 32'd0);

    // 6: reset during the third CALC cycle aborts the update.
    @(posedge clk); #1;
    set_ops(16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 4'd7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = commits;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ctrl", {28'd0, ctrl}, 32'd0);
    check("abort_step", {28'd0, step}, 32'd0);
    check("abort_deltas", {d1 | d2 | d3 | d4 | d5}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_commit", commits - c0, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Block recovers after the abort.
    run_update(16'h0040, 16'h0100, 16'hFF00, 16'h4000, 16'h0000, 16'h8001, 4'd2);
    repeat (3) @(negedge clk);
    check("final_queue", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
